// File: rtl/delay_ctrl_sequencer.sv
// Debounced faster/slower push-buttons with press-and-hold auto-repeat drive a saturating 8-bit delay.
// Press-to-pulse latency is DEBOUNCE_CYCLES+3 cycles; a software load overrides a coincident step.
module delay_ctrl_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int STEP            = 1,
  parameter int DELAY_INIT      = 128,
  parameter int DELAY_MIN       = 0,
  parameter int DELAY_MAX       = 255
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       btn_faster_n,
  input  logic       btn_slower_n,
  input  logic       load_valid,
  input  logic [7:0] load_value,
  output logic       delay_ctrl_faster,
  output logic       delay_ctrl_slower,
  output logic [7:0] delay_ctrl_delay,
  output logic       at_limit
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_DELAY  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_RATE   = TW'(REPEAT_RATE);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [8:0]    STEP9    = 9'(STEP);
  localparam logic [8:0]    MIN9     = 9'(DELAY_MIN);
  localparam logic [8:0]    MAX9     = 9'(DELAY_MAX);
  localparam logic [7:0]    MIN8     = 8'(DELAY_MIN);
  localparam logic [7:0]    MAX8     = 8'(DELAY_MAX);
  localparam logic [7:0]    INIT8    = 8'(DELAY_INIT);

  // Bit 0 is the faster button, bit 1 the slower button; all levels active-low.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [CW-1:0] cnt [2];

  assign raw = {btn_slower_n, btn_faster_n};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      deb    <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  state_t        state;
  logic          dir;       // 1 = slower (increase), 0 = faster (decrease)
  logic [TW-1:0] timer;
  logic          step_req;
  logic          press_f;
  logic          press_s;
  logic          press_held;
  logic          press_other;

  assign press_f     = ~deb[0];
  assign press_s     = ~deb[1];
  assign press_held  = dir ? press_s : press_f;
  assign press_other = dir ? press_f : press_s;

  // Release outranks a conflicting press, which outranks a timer expiry.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      dir      <= 1'b0;
      timer    <= '0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      case (state)
        IDLE: begin
          if (press_f && press_s) begin
            state <= LOCK;
          end else if (press_f || press_s) begin
            dir      <= press_s;
            step_req <= 1'b1;
            timer    <= T_DELAY;
            state    <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!press_held) begin
            state <= IDLE;
          end else if (press_other) begin
            state <= LOCK;
          end else if (timer == T_ONE) begin
            step_req <= 1'b1;
            timer    <= T_RATE;
            state    <= REPEAT;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        LOCK: begin
          if (!press_f && !press_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [8:0] cur9;
  logic [7:0] dec8;
  logic [7:0] inc8;
  logic [7:0] load8;

  // Nine-bit sums keep the saturation compares free of wrap-around.
  always_comb begin
    cur9  = {1'b0, delay_ctrl_delay};
    dec8  = (cur9 < MIN9 + STEP9) ? MIN8 : 8'(cur9 - STEP9);
    inc8  = (cur9 + STEP9 > MAX9) ? MAX8 : 8'(cur9 + STEP9);
    load8 = load_value;
    if (load_value < MIN8) begin
      load8 = MIN8;
    end else if (load_value > MAX8) begin
      load8 = MAX8;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      delay_ctrl_delay  <= INIT8;
      delay_ctrl_faster <= 1'b0;
      delay_ctrl_slower <= 1'b0;
    end else begin
      delay_ctrl_faster <= 1'b0;
      delay_ctrl_slower <= 1'b0;
      if (load_valid) begin
        delay_ctrl_delay <= load8;
      end else if (step_req) begin
        if (dir) begin
          delay_ctrl_delay  <= inc8;
          delay_ctrl_slower <= (inc8 != delay_ctrl_delay);
        end else begin
          delay_ctrl_delay  <= dec8;
          delay_ctrl_faster <= (dec8 != delay_ctrl_delay);
        end
      end
    end
  end

  assign at_limit = (delay_ctrl_delay == MIN8) || (delay_ctrl_delay == MAX8);

endmodule

// File: tb/tb_delay_ctrl_sequencer.sv
// Directed bench for delay_ctrl_sequencer: cycle-by-cycle reference model plus hand-computed checkpoints.
`timescale 1ns/1ps
module tb_delay_ctrl_sequencer;
  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;
  localparam int STP  = 1;
  localparam int INIT = 128;
  localparam int MINV = 0;
  localparam int MAXV = 255;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       bf    = 1'b1;
  logic       bs    = 1'b1;
  logic       lv    = 1'b0;
  logic [7:0] lval  = 8'd0;
  logic       lv2   = 1'b0;
  logic [7:0] lval2 = 8'd0;
  logic       f, s, al, f2, s2, al2;
  logic [7:0] dly, dly2;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int qf[$];
  int qs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  delay_ctrl_sequencer #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .STEP(STP),
    .DELAY_INIT(INIT), .DELAY_MIN(MINV), .DELAY_MAX(MAXV)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .btn_faster_n(bf), .btn_slower_n(bs),
    .load_valid(lv), .load_value(lval), .delay_ctrl_faster(f), .delay_ctrl_slower(s),
    .delay_ctrl_delay(dly), .at_limit(al)
  );

  delay_ctrl_sequencer #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .STEP(STP),
    .DELAY_INIT(INIT), .DELAY_MIN(0), .DELAY_MAX(200)
  ) dut2 (
    .clk_clk(clk), .reset_reset_n(rst_n), .btn_faster_n(1'b1), .btn_slower_n(1'b1),
    .load_valid(lv2), .load_value(lval2), .delay_ctrl_faster(f2), .delay_ctrl_slower(s2),
    .delay_ctrl_delay(dly2), .at_limit(al2)
  );

  // Reference model: button sample history, hold age since first step, delay as plain int.
  bit hf[0:D];
  bit hs[0:D];
  bit mdf, mds, mdir, mreq, mpf, mps;
  int mmode, mage, mdelay;
  bit pf, ps, held, other, nreq, flip_f, flip_s;
  int nv;

  function automatic int clampi(input int v);
    return (v < MINV) ? MINV : ((v > MAXV) ? MAXV : v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= D; i++) begin
        hf[i] = 1'b1;
        hs[i] = 1'b1;
      end
      mdf = 1'b1; mds = 1'b1; mdir = 1'b0; mreq = 1'b0; mpf = 1'b0; mps = 1'b0;
      mmode = 0; mage = 0; mdelay = INIT;
    end else begin
      mpf = 1'b0;
      mps = 1'b0;
      if (lv) begin
        mdelay = clampi(int'(lval));
      end else if (mreq) begin
        nv = clampi(mdir ? mdelay + STP : mdelay - STP);
        if (nv != mdelay) begin
          if (mdir) mps = 1'b1; else mpf = 1'b1;
          mdelay = nv;
        end
      end
      pf = !mdf;
      ps = !mds;
      nreq = 1'b0;
      case (mmode)
        0: begin
          if (pf && ps) mmode = 2;
          else if (pf || ps) begin
            mdir = ps; nreq = 1'b1; mage = 0; mmode = 1;
          end
        end
        1: begin
          mage++;
          held  = mdir ? ps : pf;
          other = mdir ? pf : ps;
          if (!held) mmode = 0;
          else if (other) mmode = 2;
          else nreq = (mage == RD) || (mage > RD && ((mage - RD) % RR) == 0);
        end
        default: if (!pf && !ps) mmode = 0;
      endcase
      mreq = nreq;
      flip_f = 1'b1;
      flip_s = 1'b1;
      for (int i = 1; i <= D; i++) begin
        if (hf[i] == mdf) flip_f = 1'b0;
        if (hs[i] == mds) flip_s = 1'b0;
      end
      if (flip_f) mdf = !mdf;
      if (flip_s) mds = !mds;
      for (int i = D; i > 0; i--) begin
        hf[i] = hf[i-1];
        hs[i] = hs[i-1];
      end
      hf[0] = bf;
      hs[0] = bs;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (f !== mpf || s !== mps || dly !== 8'(mdelay) || al !== (mdelay == MINV || mdelay == MAXV)) begin
      miscompares++;
      $display("FAIL model_cmp cyc=%0d: dut f=%b s=%b delay=%0d lim=%b, model f=%b s=%b delay=%0d lim=%b",
               cyc, f, s, dly, al, mpf, mps, mdelay, (mdelay == MINV || mdelay == MAXV));
    end
    if (f === 1'b1) qf.push_back(cyc);
    if (s === 1'b1) qs.push_back(cyc);
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    qf.delete();
    qs.delete();
  endtask

  task automatic tap(input bit slow, input int len, output int n);
    tick();
    if (slow) bs = 1'b0; else bf = 1'b0;
    n = cyc + 1;
    repeat (len) tick();
    bs = 1'b1;
    bf = 1'b1;
  endtask

  task automatic load(input int v);
    tick();
    lv = 1'b1;
    lval = 8'(v);
    tick();
    lv = 1'b0;
  endtask

  int n;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("reset_faster", int'(f), 0);
    check("reset_slower", int'(s), 0);
    check("reset_delay", int'(dly), 128);
    check("reset_at_limit", int'(al), 0);
    check("reset_delay_dut2", int'(dly2), 128);

    // Single tap on slower
    clear_q();
    tap(1'b1, 10, n);
    repeat (15) tick();
    check("tap_slower_count", qs.size(), 1);
    check("tap_slower_time", qat(qs, 0), n + 7);
    check("tap_faster_count", qf.size(), 0);
    check("tap_delay", int'(dly), 129);

    // Hold faster for 60 cycles
    clear_q();
    tap(1'b0, 60, n);
    repeat (30) tick();
    check("hold_count", qf.size(), 9);
    check("hold_first", qat(qf, 0), n + 7);
    check("hold_second", qat(qf, 1), n + 27);
    check("hold_third", qat(qf, 2), n + 32);
    check("hold_last", qat(qf, 8), n + 62);
    check("hold_slower_count", qs.size(), 0);
    check("hold_delay", int'(dly), 120);

    // Short glitch
    clear_q();
    tap(1'b0, 3, n);
    repeat (15) tick();
    check("glitch_count", qf.size() + qs.size(), 0);
    check("glitch_delay", int'(dly), 120);

    // Both pressed, released one at a time
    clear_q();
    tick();
    bf = 1'b0;
    bs = 1'b0;
    repeat (20) tick();
    bs = 1'b1;
    repeat (20) tick();
    check("lock_one_released_count", qf.size() + qs.size(), 0);
    bf = 1'b1;
    repeat (20) tick();
    check("lock_count", qf.size() + qs.size(), 0);
    check("lock_delay", int'(dly), 120);
    tap(1'b1, 10, n);
    repeat (15) tick();
    check("after_lock_count", qs.size(), 1);
    check("after_lock_time", qat(qs, 0), n + 7);
    check("after_lock_delay", int'(dly), 121);

    // Upper saturation
    clear_q();
    load(254);
    check("load254_delay", int'(dly), 254);
    check("load254_at_limit", int'(al), 0);
    repeat (3) begin
      tap(1'b1, 10, n);
      repeat (15) tick();
    end
    check("sat_hi_count", qs.size(), 1);
    check("sat_hi_delay", int'(dly), 255);
    check("sat_hi_at_limit", int'(al), 1);

    // Clamp on a narrower range
    tick();
    lv2 = 1'b1;
    lval2 = 8'd250;
    tick();
    lv2 = 1'b0;
    check("clamp_delay_dut2", int'(dly2), 200);
    check("clamp_at_limit_dut2", int'(al2), 1);
    tick();
    lv2 = 1'b1;
    lval2 = 8'd150;
    tick();
    lv2 = 1'b0;
    check("inrange_delay_dut2", int'(dly2), 150);
    check("inrange_at_limit_dut2", int'(al2), 0);

    // Lower saturation
    clear_q();
    load(1);
    repeat (2) begin
      tap(1'b0, 10, n);
      repeat (15) tick();
    end
    check("sat_lo_count", qf.size(), 1);
    check("sat_lo_delay", int'(dly), 0);
    check("sat_lo_at_limit", int'(al), 1);

    // Load coinciding with the first step of a hold
    load(100);
    clear_q();
    tick();
    bf = 1'b0;
    n = cyc + 1;
    repeat (7) tick();
    lv = 1'b1;
    lval = 8'd10;
    tick();
    lv = 1'b0;
    check("collide_delay", int'(dly), 10);
    check("collide_pulse", int'(f), 0);
    repeat (22) tick();
    bf = 1'b1;
    repeat (20) tick();
    check("collide_count", qf.size(), 2);
    check("collide_first", qat(qf, 0), n + 27);
    check("collide_second", qat(qf, 1), n + 32);
    check("collide_delay_end", int'(dly), 8);

    // Reset in the middle of a hold
    clear_q();
    tick();
    bs = 1'b0;
    repeat (12) tick();
    check("midhold_delay", int'(dly), 9);
    rst_n = 1'b0;
    bs = 1'b1;
    #1;
    check("midreset_faster", int'(f), 0);
    check("midreset_slower", int'(s), 0);
    check("midreset_delay", int'(dly), 128);
    check("midreset_at_limit", int'(al), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    clear_q();
    repeat (20) tick();
    check("postreset_count", qf.size() + qs.size(), 0);
    check("postreset_delay", int'(dly), 128);
    tap(1'b1, 10, n);
    repeat (15) tick();
    check("postreset_tap_count", qs.size(), 1);
    check("postreset_tap_time", qat(qs, 0), n + 7);
    check("postreset_tap_delay", int'(dly), 129);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
